// File: rtl/rcfg_strm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rcfg_strm_ctrl_pkg
// Brief    : Shared types and constants for the reconfiguration streamer:
//            FSM state encoding, ROM word field positions, end marker and
//            the reconfiguration profile table.
// Revision : 1.0 - initial release
// ============================================================================
package rcfg_strm_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ROM_RD = 4'd1,
        ST_DECODE = 4'd2,
        ST_READ   = 4'd3,
        ST_MODIFY = 4'd4,
        ST_WRITE  = 4'd5,
        ST_DONE   = 4'd6,
        ST_ERR    = 4'd7
    } state_t;

    // ROM word layout: {addr[25:16], mask[15:8], data[7:0]}
    localparam int ADDR_LSB = 16;
    localparam int MASK_LSB = 8;
    localparam int DATA_LSB = 0;

    localparam logic [25:0] END_MARKER = 26'h3FFFFFF;

    // Reconfiguration parameter table, profiles laid out back to back.
    // Any index past the table reads as the end marker.
    function automatic logic [25:0] rom_word(input int idx);
        case (idx)
            0:       rom_word = 26'h1350C00;
            1:       rom_word = 26'h13A3828;
            2:       rom_word = END_MARKER;
            3:       rom_word = 26'h1350F03;
            4:       rom_word = 26'h13A3830;
            5:       rom_word = END_MARKER;
            default: rom_word = END_MARKER;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rcfg_strm_rom.sv
`default_nettype none
// ============================================================================
// Module   : rcfg_strm_rom
// Brief    : Registered reconfiguration ROM, one-cycle read latency,
//            contents taken from the profile table in rcfg_strm_ctrl_pkg.
// Revision : 1.0 - initial release
// ============================================================================
module rcfg_strm_rom
    import rcfg_strm_ctrl_pkg::*;
#(
    parameter int DEPTH  = 6,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 26
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Registered lookup; addresses beyond DEPTH return the end marker.
    always_ff @(posedge clk) begin
        if (32'(i_addr) < 32'(DEPTH)) begin
            r_q <= DATA_W'(rom_word(int'(i_addr)));
        end else begin
            r_q <= {DATA_W{1'b1}};
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/rcfg_strm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rcfg_strm_ctrl
// Brief    : Reconfiguration streamer. Walks one ROM profile and performs a
//            read-modify-write of a PHY register over Avalon-MM per entry.
//            Optional macro RCFG_STRM_TIMEOUT_EN adds a waitrequest timeout
//            that aborts the stream with an error pulse.
// Revision : 1.0 - initial release
// ============================================================================
module rcfg_strm_ctrl
    import rcfg_strm_ctrl_pkg::*;
#(
    parameter int NUM_PROFILES    = 2,
    parameter int PROFILE_DEPTH   = 3,
    parameter int ROM_DATA_WIDTH  = 26,
    parameter int AVMM_ADDR_WIDTH = 10,
    parameter int AVMM_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                                  reconfig_clk,
    input  logic                                                  reconfig_reset,
    input  logic                                                  start,
    input  logic [((NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1)-1:0] profile_sel,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  error,
    output logic [AVMM_ADDR_WIDTH-1:0]                            reconfig_address,
    output logic                                                  reconfig_read,
    output logic                                                  reconfig_write,
    output logic [AVMM_DATA_WIDTH-1:0]                            reconfig_writedata,
    input  logic [AVMM_DATA_WIDTH-1:0]                            reconfig_readdata,
    input  logic                                                  reconfig_waitrequest
);

    localparam int          c_rom_depth    = NUM_PROFILES * PROFILE_DEPTH;
    localparam int          c_idx_w        = (c_rom_depth > 1) ? $clog2(c_rom_depth) : 1;
    localparam int          c_ent_w        = (PROFILE_DEPTH > 1) ? $clog2(PROFILE_DEPTH) : 1;
    localparam logic [31:0] c_num_profiles = 32'(NUM_PROFILES);

    state_t                     r_state;
    logic [c_idx_w-1:0]         r_index;
    logic [c_ent_w-1:0]         r_entry;
    logic [AVMM_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                 r_mask;
    logic [7:0]                 r_data;
    logic [AVMM_DATA_WIDTH-1:0] r_rdata;
    logic [AVMM_DATA_WIDTH-1:0] r_wdata;
    logic                       r_read;
    logic                       r_write;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_error;

    logic [ROM_DATA_WIDTH-1:0]  w_rom_q;
    logic                       w_sel_ok;
    logic [c_idx_w-1:0]         w_base;
    logic                       w_last_entry;
    logic                       w_timeout;

    assign w_sel_ok     = 32'(profile_sel) < c_num_profiles;
    assign w_base       = c_idx_w'(profile_sel) * c_idx_w'(PROFILE_DEPTH);
    assign w_last_entry = (r_entry == c_ent_w'(PROFILE_DEPTH - 1));

    rcfg_strm_rom #(
        .DEPTH  (c_rom_depth),
        .ADDR_W (c_idx_w),
        .DATA_W (ROM_DATA_WIDTH)
    ) u_rom (
        .clk    (reconfig_clk),
        .i_addr (r_index),
        .o_q    (w_rom_q)
    );

`ifdef RCFG_STRM_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_to_w-1:0] r_wait_cnt;

    assign w_timeout = reconfig_waitrequest && (r_wait_cnt == c_to_w'(TIMEOUT_CYCLES - 1));

    // Count consecutive stalled bus cycles; any completed transfer restarts it.
    always_ff @(posedge reconfig_clk) begin
        if (reconfig_reset) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_READ || r_state == ST_WRITE) && reconfig_waitrequest) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Stream sequencer: fetch entry, read register, merge masked bits, write back.
    always_ff @(posedge reconfig_clk) begin
        if (reconfig_reset) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_entry <= '0;
            r_addr  <= '0;
            r_mask  <= '0;
            r_data  <= '0;
            r_rdata <= '0;
            r_wdata <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_sel_ok) begin
                            r_index <= w_base;
                            r_entry <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_ROM_RD;
                        end else begin
                            // Bad profile: report without touching the bus.
                            r_error <= 1'b1;
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_ROM_RD: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_rom_q == END_MARKER) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_addr  <= w_rom_q[ADDR_LSB +: AVMM_ADDR_WIDTH];
                        r_mask  <= w_rom_q[MASK_LSB +: 8];
                        r_data  <= w_rom_q[DATA_LSB +: 8];
                        r_read  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!reconfig_waitrequest) begin
                        r_rdata <= reconfig_readdata;
                        r_read  <= 1'b0;
                        r_state <= ST_MODIFY;
                    end else if (w_timeout) begin
                        r_read  <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= ST_ERR;
                    end
                end
                ST_MODIFY: begin
                    r_wdata <= {r_rdata[AVMM_DATA_WIDTH-1:8],
                                (r_rdata[7:0] & ~r_mask) | (r_data & r_mask)};
                    r_write <= 1'b1;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (!reconfig_waitrequest) begin
                        r_write <= 1'b0;
                        if (w_last_entry) begin
                            // Profile exhausted without a marker; never spill into the next one.
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_entry <= r_entry + 1'b1;
                            r_state <= ST_ROM_RD;
                        end
                    end else if (w_timeout) begin
                        r_write <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= ST_ERR;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign error              = r_error;
    assign reconfig_address   = r_addr;
    assign reconfig_read      = r_read;
    assign reconfig_write     = r_write;
    assign reconfig_writedata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rcfg_strm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rcfg_strm_ctrl
// Brief    : Scoreboard bench for rcfg_strm_ctrl. A driver issues streams and
//            queues the expected bus writes and done/error events; a monitor
//            compares them as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rcfg_strm_ctrl;

    localparam int c_to = 16;

    typedef struct {
        int          kind;   // 0 write, 1 done, 2 error
        logic [9:0]  addr;
        logic [31:0] data;
        longint      cyc;    // expected cycle, -1 when not checked
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [0:0]  psel = 1'b0;
    logic        busy, done, err, rd, wr;
    logic [9:0]  addr;
    logic [31:0] wdata, rdata;
    logic        wreq = 1'b0;

    logic        start1 = 1'b0;
    logic [0:0]  psel1 = 1'b0;
    logic        busy1, done1, err1, rd1, wr1;
    logic [9:0]  addr1;
    logic [31:0] wdata1;

    exp_t        exp_q[$];
    logic [31:0] mem_act [1024];
    logic [31:0] mem_mdl [1024];
    logic [25:0] rom_m [6];
    int          stall_mode = 0;
    bit          force_stall = 1'b0;
    longint      cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    rcfg_strm_ctrl #(.TIMEOUT_CYCLES(c_to)) u_dut (
        .reconfig_clk         (clk),
        .reconfig_reset       (rst),
        .start                (start),
        .profile_sel          (psel),
        .busy                 (busy),
        .done                 (done),
        .error                (err),
        .reconfig_address     (addr),
        .reconfig_read        (rd),
        .reconfig_write       (wr),
        .reconfig_writedata   (wdata),
        .reconfig_readdata    (rdata),
        .reconfig_waitrequest (wreq)
    );

    // Single-profile instance: profile_sel = 1 is out of range here.
    rcfg_strm_ctrl #(.NUM_PROFILES(1), .TIMEOUT_CYCLES(c_to)) u_dut1 (
        .reconfig_clk         (clk),
        .reconfig_reset       (rst),
        .start                (start1),
        .profile_sel          (psel1),
        .busy                 (busy1),
        .done                 (done1),
        .error                (err1),
        .reconfig_address     (addr1),
        .reconfig_read        (rd1),
        .reconfig_write       (wr1),
        .reconfig_writedata   (wdata1),
        .reconfig_readdata    (32'h0),
        .reconfig_waitrequest (1'b0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdata = mem_act[addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    endtask

    // Slave responder: stall pattern chosen per transfer.
    int left = 0;
    bit in_xfer = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rd || wr) begin
            if (!in_xfer) begin
                in_xfer = 1'b1;
                case (stall_mode)
                    0:       left = 0;
                    1:       left = 4;
                    2:       left = $urandom_range(0, 3);
                    default: left = 1000000;
                endcase
            end
            wreq = (left > 0) || (force_stall && wr);
            if (left > 0) left--;
        end else begin
            in_xfer = 1'b0;
            wreq    = 1'b0;
        end
    end

    task automatic expect_evt(input int kind, input logic [9:0] a, input logic [31:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_evt: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("evt_kind", 64'(kind), 64'(e.kind));
            if (e.kind == 0 && kind == 0) begin
                chk("wr_addr", 64'(a), 64'(e.addr));
                chk("wr_data", 64'(d), 64'(e.data));
            end
            if (e.cyc >= 0) chk("evt_cycle", 64'(cyc), 64'(e.cyc));
        end
    endtask

    // Monitor: protocol checks and scoreboard pops on accepted writes and pulses.
    logic        p_rd = 1'b0, p_wr = 1'b0, p_wreq = 1'b0;
    logic [9:0]  p_addr = '0;
    logic [31:0] p_wdata = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (rd || wr) chk("rd_wr_exclusive", 64'(rd && wr), 64'd0);
            if (rd && p_rd && p_wreq) chk("rd_addr_stable", 64'(addr), 64'(p_addr));
            if (wr && p_wr && p_wreq) begin
                chk("wr_addr_stable", 64'(addr), 64'(p_addr));
                chk("wr_data_stable", 64'(wdata), 64'(p_wdata));
            end
            if (wr && !wreq) begin
                mem_act[addr] = wdata;
                expect_evt(0, addr, wdata);
            end
            if (done) expect_evt(1, '0, '0);
            if (err)  expect_evt(2, '0, '0);
        end
        p_rd = rd; p_wr = wr; p_wreq = wreq; p_addr = addr; p_wdata = wdata;
    end

    // Issue one stream and queue what the reference rules predict for it.
    task automatic run_stream(input int sel, input int mode, input bit repulse);
        longint      n;
        int          nent;
        bit          hit;
        int          per;
        exp_t        e;
        logic [25:0] w;
        logic [31:0] r;
        int          k;
        stall_mode = mode;
        @(posedge clk); #2;
        n = cyc; nent = 0; hit = 1'b0;
        if (mode != 3) begin
            for (int i = 0; i < 3; i++) begin
                w = rom_m[sel*3 + i];
                if (w == 26'h3FFFFFF) begin hit = 1'b1; break; end
                r = mem_mdl[w[25:16]];
                e.kind = 0; e.addr = w[25:16];
                e.data = {r[31:8], (r[7:0] & ~w[15:8]) | (w[7:0] & w[15:8])};
                e.cyc  = -1;
                mem_mdl[w[25:16]] = e.data;
                exp_q.push_back(e);
                nent++;
            end
            per = (mode == 1) ? 13 : 5;
            e.kind = 1; e.addr = '0; e.data = '0;
            e.cyc  = (mode <= 1) ? n + (hit ? 3 : 1) + per*nent : -1;
            exp_q.push_back(e);
        end else begin
            e.kind = 2; e.addr = '0; e.data = '0; e.cyc = n + 3 + c_to;
            exp_q.push_back(e);
        end
        start = 1'b1; psel = 1'(sel);
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        if (repulse) begin
            repeat (3) @(posedge clk);
            #2; start = 1'b1; psel = ~psel;
            @(posedge clk); #2; start = 1'b0;
        end
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin @(posedge clk); k++; end
        if (exp_q.size() != 0) begin
            chk("stream_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        #2;
        chk("busy_low_after_end", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #2;
        chk("idle_stays_idle", 64'({busy, rd, wr}), 64'd0);
        stall_mode = 0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] v);
        mem_act[a] = v;
        mem_mdl[a] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        rom_m[0] = 26'h1350C00; rom_m[1] = 26'h13A3828; rom_m[2] = 26'h3FFFFFF;
        rom_m[3] = 26'h1350F03; rom_m[4] = 26'h13A3830; rom_m[5] = 26'h3FFFFFF;
        for (int i = 0; i < 1024; i++) begin mem_act[i] = '0; mem_mdl[i] = '0; end

        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", 64'({busy, done, err, rd, wr, addr, wdata}), 64'd0);
        chk("reset_outputs_inst1", 64'({busy1, done1, err1, rd1, wr1, addr1, wdata1}), 64'd0);
        rst = 1'b0;

        // Profile 0, known read data, no stalls.
        preload(10'h135, 32'h0000005F);
        preload(10'h13A, 32'h00000000);
        run_stream(0, 0, 1'b0);
        chk("p0_reg135", 64'(mem_act[10'h135]), 64'h53);
        chk("p0_reg13a", 64'(mem_act[10'h13A]), 64'h28);

        // Profile 1, upper readdata bits must survive.
        preload(10'h135, 32'hA5A5A5FF);
        preload(10'h13A, 32'hA5A5A5FF);
        run_stream(1, 0, 1'b0);
        chk("p1_reg135", 64'(mem_act[10'h135]), 64'hA5A5A5F3);
        chk("p1_reg13a", 64'(mem_act[10'h13A]), 64'hA5A5A5F7);

        // Four-cycle stall on every transfer.
        run_stream(0, 1, 1'b0);

        // Out-of-range profile on the single-profile instance.
        @(posedge clk); #2;
        start1 = 1'b1; psel1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        chk("inv_error_n1", 64'(err1), 64'd1);
        chk("inv_no_busy_rw", 64'({busy1, rd1, wr1, done1}), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            chk("inv_quiet", 64'({busy1, rd1, wr1, done1, err1}), 64'd0);
        end

        // Restart pulse while busy is ignored.
        run_stream(1, 0, 1'b1);

        // Reset during a stalled write, then a clean full run.
        force_stall = 1'b1;
        @(posedge clk); #2;
        start = 1'b1; psel = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2; start = 1'b1; psel = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        k = 0;
        while (!wr && k < 100) begin @(posedge clk); #2; k++; end
        chk("reached_write", 64'(wr), 64'd1);
        repeat (2) @(posedge clk);
        #2; rst = 1'b1;
        @(posedge clk); #2;
        chk("midstream_reset_outputs", 64'({busy, done, err, rd, wr, addr, wdata}), 64'd0);
        rst = 1'b0; force_stall = 1'b0;
        exp_q.delete();
        run_stream(0, 0, 1'b0);

        // Randomized streams.
        for (int it = 0; it < 16; it++) begin
            preload(10'h135, $urandom);
            preload(10'h13A, $urandom);
            run_stream($urandom_range(0, 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

`ifdef RCFG_STRM_TIMEOUT_EN
        // Waitrequest stuck high: stream must abort with an error.
        run_stream(0, 3, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
